// File: rtl/sort_pkg.sv
// Shared types and default geometry for the sorter write-back stage.
package sort_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_BITS  = 8;
    localparam int DEF_ADDR  = 12;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    typedef logic [DEF_WIDTH-1:0][DEF_BITS-1:0] chunk_t;

endpackage

// File: rtl/sort_wb_fifo.sv
// Synchronous chunk FIFO; write lands next cycle, head read is combinational from registered state.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module sort_wb_fifo #(
    parameter int DW    = 44,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    output logic                     push_acc,
    output logic                     pop_acc,
    output logic [DW-1:0]            head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);

    // Head is forced to zero when empty so stale storage never leaks out, including under reset.
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/sort_writeback.sv
// Buffers sorted chunks and writes them to SRAM; one-cycle push-to-wr_en, one chunk/cycle sustained.
// Never stalls the sorter: pushes into a full FIFO without a same-cycle pop are dropped and flagged.
module sort_writeback
    import sort_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BITS      = DEF_BITS,
    parameter int ADDR      = DEF_ADDR,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit CHECK_ASC = 1'b1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      sort_active,
    input  logic                      sort_valid,
    input  logic [WIDTH*BITS-1:0]     sorted,
    input  logic [ADDR-1:0]           sorted_addr,
    output logic                      wr_en,
    input  logic                      wr_ready,
    output logic [ADDR-1:0]           wr_addr,
    output logic [WIDTH*BITS-1:0]     wr_data,
    output logic [ADDR:0]             wr_count,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic                      order_err,
    output logic                      sort_done
);
    localparam int DW = ADDR + WIDTH*BITS;

    wb_state_t state_q, state_d;
    logic [ADDR:0] wr_count_q, wr_count_d;
    logic          overflow_q, overflow_d;
    logic          order_err_q, order_err_d;

    logic          push_acc, pop_acc, fifo_full, fifo_empty;
    logic [DW-1:0] head_dat;
    logic          session_start, unsorted;
    logic [WIDTH-1:0][BITS-1:0] entries;

    sort_wb_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstb     (rstb),
        .push     (sort_valid),
        .push_dat ({sorted_addr, sorted}),
        .pop      (wr_ready),
        .push_acc (push_acc),
        .pop_acc  (pop_acc),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign wr_en   = !fifo_empty;
    assign wr_addr = head_dat[DW-1 -: ADDR];
    assign wr_data = head_dat[WIDTH*BITS-1:0];

    assign entries = sorted;

    always_comb begin
        unsorted = 1'b0;
        for (int i = 0; i < WIDTH-1; i++) begin
            if (entries[i+1] < entries[i]) unsorted = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        session_start = 1'b0;
        case (state_q)
            IDLE: if (sort_active) begin
                state_d       = RUN;
                session_start = 1'b1;
            end
            RUN:   if (!sort_active) state_d = DRAIN;
            DRAIN: if (fifo_empty && !sort_valid) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Session start clears first, so an event in the same cycle still lands in the new session.
    always_comb begin
        wr_count_d  = session_start ? '0 : wr_count_q;
        overflow_d  = session_start ? 1'b0 : overflow_q;
        order_err_d = session_start ? 1'b0 : order_err_q;
        if (pop_acc && (wr_count_d != '1)) wr_count_d = wr_count_d + 1'b1;
        if (sort_valid && fifo_full && !pop_acc) overflow_d = 1'b1;
        if (CHECK_ASC && push_acc && unsorted) order_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            wr_count_q  <= '0;
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            overflow_q  <= overflow_d;
            order_err_q <= order_err_d;
        end
    end

    assign wr_count  = wr_count_q;
    assign overflow  = overflow_q;
    assign order_err = order_err_q;
    assign sort_done = (state_q == DONE);

endmodule

// File: tb/tb_sort_writeback.sv
// Scoreboard bench for sort_writeback: accepted pushes queue expected writes, a monitor checks each pop.
module tb_sort_writeback;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        sort_active = 1'b0;
    logic        sort_valid = 1'b0;
    logic [31:0] sorted = '0;
    logic [11:0] sorted_addr = '0;
    logic        wr_ready = 1'b0;

    logic        wr_en, overflow, order_err, sort_done;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [12:0] wr_count;
    logic [2:0]  fifo_level;

    logic        wr_en2, overflow2, order_err2, sort_done2;
    logic [11:0] wr_addr2;
    logic [31:0] wr_data2;
    logic [12:0] wr_count2;
    logic [2:0]  fifo_level2;

    int nchecks = 0;
    int nfail = 0;
    int done_cnt = 0;
    logic [43:0] expq[$];

    always #5 clk = ~clk;

    sort_writeback dut (
        .clk(clk), .rstb(rstb), .sort_active(sort_active), .sort_valid(sort_valid),
        .sorted(sorted), .sorted_addr(sorted_addr), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_count(wr_count), .fifo_level(fifo_level),
        .overflow(overflow), .order_err(order_err), .sort_done(sort_done)
    );

    sort_writeback #(.CHECK_ASC(1'b0)) dut_nochk (
        .clk(clk), .rstb(rstb), .sort_active(sort_active), .sort_valid(sort_valid),
        .sorted(sorted), .sorted_addr(sorted_addr), .wr_en(wr_en2), .wr_ready(wr_ready),
        .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_count(wr_count2), .fifo_level(fifo_level2),
        .overflow(overflow2), .order_err(order_err2), .sort_done(sort_done2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d, input bit exp_acc);
        sort_valid  = 1'b1;
        sorted_addr = a;
        sorted      = d;
        if (exp_acc) expq.push_back({a, d});
        tick();
        sort_valid = 1'b0;
    endtask

    function automatic logic [31:0] asc(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always @(negedge clk) begin
        if (rstb && wr_en && wr_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_write", {52'd0, wr_addr}, 64'hFFF);
            end else begin
                logic [43:0] e;
                e = expq.pop_front();
                check("wr_addr", {52'd0, wr_addr}, {52'd0, e[43:32]});
                check("wr_data", {32'd0, wr_data}, {32'd0, e[31:0]});
            end
        end
        if (rstb && sort_done) done_cnt++;
    end

    initial begin
        // Reset state
        #12;
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_level", {61'd0, fifo_level}, 64'd0);
        check("rst_wr_addr", {52'd0, wr_addr}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check("rst_count", {51'd0, wr_count}, 64'd0);
        check("rst_flags", {61'd0, overflow, order_err, sort_done}, 64'd0);
        tick();
        rstb = 1'b1;
        tick();

        // Single write
        wr_ready    = 1'b1;
        sort_active = 1'b1;
        tick();
        push(12'h010, 32'h04030201, 1'b1);
        check("single_wr_en", {63'd0, wr_en}, 64'd1);
        tick();
        check("single_count", {51'd0, wr_count}, 64'd1);
        check("single_level", {61'd0, fifo_level}, 64'd0);
        sort_active = 1'b0;
        ticks(8);
        check("single_done", done_cnt, 64'd1);
        check("single_overflow", {63'd0, overflow}, 64'd0);
        check("single_order", {63'd0, order_err}, 64'd0);

        // Backpressure then overflow
        wr_ready    = 1'b0;
        sort_active = 1'b1;
        tick();
        check("s2_count_clr", {51'd0, wr_count}, 64'd0);
        for (int a = 0; a < 4; a++) push(12'(a), asc(8'(a * 16)), 1'b1);
        check("bp_level", {61'd0, fifo_level}, 64'd4);
        check("bp_addr", {52'd0, wr_addr}, 64'd0);
        tick();
        check("bp_addr_hold", {52'd0, wr_addr}, 64'd0);
        check("bp_data_hold", {32'd0, wr_data}, {32'd0, asc(8'd0)});
        push(12'h009, asc(8'h90), 1'b0);
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        check("ovf_level", {61'd0, fifo_level}, 64'd4);
        wr_ready = 1'b1;
        ticks(6);
        check("bp_count", {51'd0, wr_count}, 64'd4);
        check("bp_drained", {61'd0, fifo_level}, 64'd0);
        sort_active = 1'b0;
        ticks(8);
        check("s2_done", done_cnt, 64'd2);
        check("ovf_sticky", {63'd0, overflow}, 64'd1);

        // Full push+pop, then order error
        wr_ready    = 1'b0;
        sort_active = 1'b1;
        tick();
        check("ovf_cleared", {63'd0, overflow}, 64'd0);
        for (int a = 0; a < 4; a++) push(12'h020 + 12'(a), asc(8'(a)), 1'b1);
        check("full_level", {61'd0, fifo_level}, 64'd4);
        wr_ready = 1'b1;
        push(12'h007, asc(8'h70), 1'b1);
        check("pp_level", {61'd0, fifo_level}, 64'd4);
        check("pp_no_ovf", {63'd0, overflow}, 64'd0);
        ticks(6);
        check("pp_queue_empty", expq.size(), 64'd0);
        check("pp_order_ok", {63'd0, order_err}, 64'd0);
        push(12'h030, 32'h07060305, 1'b1);
        check("order_err", {63'd0, order_err}, 64'd1);
        check("order_err_nochk", {63'd0, order_err2}, 64'd0);
        ticks(3);
        sort_active = 1'b0;
        ticks(8);
        check("s3_done", done_cnt, 64'd3);
        check("s3_count", {51'd0, wr_count}, 64'd6);

        // Reset mid-drain
        wr_ready    = 1'b0;
        sort_active = 1'b1;
        tick();
        for (int a = 0; a < 3; a++) push(12'h040 + 12'(a), asc(8'(a)), 1'b1);
        sort_active = 1'b0;
        tick();
        rstb = 1'b0;
        #1;
        check("rd_wr_en", {63'd0, wr_en}, 64'd0);
        check("rd_level", {61'd0, fifo_level}, 64'd0);
        check("rd_wr_addr", {52'd0, wr_addr}, 64'd0);
        expq.delete();
        ticks(2);
        rstb     = 1'b1;
        wr_ready = 1'b1;
        ticks(8);
        check("rd_no_done", done_cnt, 64'd3);
        check("rd_idle_wr_en", {63'd0, wr_en}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/sort_writeback.md
# sort_writeback

Write-back stage downstream of the bitonic sorter. It accepts each sorted `WIDTH`-entry chunk with its destination address, buffers it in a small FIFO, and drives the SRAM write port with a valid/ready handshake. It also counts completed writes, flags FIFO overflow and intra-chunk ordering errors, and pulses `sort_done` once a sort session has ended and every buffered chunk has been written.

## Interface
- `WIDTH`, 4, entries per chunk
- `BITS`, 8, bits per entry (unsigned)
- `ADDR`, 12, SRAM address width
- `DEPTH`, 4, FIFO depth in chunks (power of 2, ≥2)
- `CHECK_ASC`, 1, 1 enables the ascending-order check; 0 forces `order_err` to 0

Ports (rstb asynchronous, active-low; clock clk):
- `clk` in 1 clock
- `rstb` in 1 asynchronous active-low reset
- `sort_active` in 1 sorter session active
- `sort_valid` in 1 chunk push strobe
- `sorted` in `WIDTH*BITS` chunk, entry i at `[i*BITS +: BITS]`
- `sorted_addr` in `ADDR` destination address
- `wr_en` out 1 write request (FIFO not empty)
- `wr_ready` in 1 SRAM write port accepts this cycle
- `wr_addr` out `ADDR` head-of-FIFO address
- `wr_data` out `WIDTH*BITS` head-of-FIFO data
- `wr_count` out `ADDR+1` writes completed this session
- `fifo_level` out `$clog2(DEPTH)+1` occupancy
- `overflow` out 1 sticky, a push was dropped
- `order_err` out 1 sticky, a pushed chunk was not ascending
- `sort_done` out 1 one-cycle session-complete pulse

## Operation
- **Push:** `sort_valid` writes {`sorted_addr`, `sorted`} into the FIFO. Pushes are accepted in every state. The block never stalls the sorter.
- **Pop:** fires when `wr_en && wr_ready`. FIFO advances, `wr_count` increments. It saturates at all-ones.
- **Full:**
  - Push while full with no pop is dropped and sets `overflow`.
  - Push and pop in the same cycle while full are both accepted; level is unchanged.
- **Empty:** a push into an empty FIFO makes `wr_en` high the next cycle. There is no bypass.
- **Order check:** on each accepted push, if `CHECK_ASC` is set and `sorted[i+1] < sorted[i]` for any i, set `order_err`.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `sort_active` = 1. This transition clears `wr_count`, `overflow` and `order_err`. The FIFO is not flushed.
  - RUN → DRAIN on `sort_active` = 0.
  - DRAIN → DONE when the FIFO is empty and there is no push this cycle.
  - DONE → IDLE unconditionally. `sort_done` = 1 only in DONE.
  - If `sort_active` rises during DRAIN or DONE, completion still occurs. IDLE then enters RUN on the next cycle.
- **Outputs under reset:** reset mid-operation discards FIFO contents; no further writes are issued. While `rstb` is low:
  - `wr_en`, `sort_done`, `overflow`, `order_err` = 0
  - `wr_count`, `fifo_level`, `wr_addr`, `wr_data` = 0
  - FSM = IDLE

## Timing
- All outputs are registered or decoded from registered FIFO state. There is no combinational path from `sort_valid` or `sorted` to any output.
- `wr_en` is combinational from FIFO state only. `wr_ready` affects only the next-cycle state.
- Push at cycle N gives earliest `wr_en` at N+1 and earliest pop at N+1. Sustained throughput is one chunk per cycle when `wr_ready` = 1.
- `wr_addr` and `wr_data` hold stable while `wr_en && !wr_ready`.
- `order_err`, `overflow` and `wr_count` update the cycle after the causing event.
- `sort_done` is asserted the cycle after the DRAIN exit condition. `sort_active` low to `sort_done`: at least 2 cycles when the FIFO is empty.

## Structure
- Package `sort_pkg`:
  - default `WIDTH`, `BITS`, `ADDR` localparams
  - `wb_state_t` enum {IDLE, RUN, DRAIN, DONE}
  - chunk typedef `logic [WIDTH-1:0][BITS-1:0]`
- Sub-module `sort_wb_fifo`:
  - synchronous FIFO with push, pop, full, empty, level
  - storage width `ADDR+WIDTH*BITS`, depth `DEPTH`, pointers one bit wider than the index
- Top level contains the FSM, counters, order check and sticky flags.

## Test plan
- **Single write:** `sort_active` = 1, one push addr 0x010 data {1,2,3,4}, `wr_ready` = 1 → `wr_en` one cycle later with 0x010/{1,2,3,4}; `wr_count` = 1. Drop `sort_active` → `sort_done` pulse, `overflow` = 0, `order_err` = 0.
- **Backpressure:** `wr_ready` = 0, 4 pushes (addr 0..3) → `fifo_level` = 4, `wr_addr` holds 0. Raise `wr_ready` → 4 writes in order, addr 0..3.
- **Overflow:** `DEPTH` = 4 full, `wr_ready` = 0, 5th push → dropped, `overflow` = 1, `fifo_level` stays 4. Next session start clears `overflow`.
- **Full push+pop:** FIFO full, push addr 0x7 with `wr_ready` = 1 same cycle → level 4, no overflow, 0x7 written last.
- **Order error:** push {5,3,6,7} → `order_err` = 1. With `CHECK_ASC` = 0 → `order_err` stays 0.
- **Reset mid-drain:** 3 entries queued, `sort_active` = 0, assert `rstb` low → `wr_en` = 0, `fifo_level` = 0 immediately; no `sort_done` after release.
